// File: rtl/blur_writeback_if.sv
// Handshake/bus bundle between the blur convolver, the writeback stage and the blurred-image memory.
interface blur_writeback_if #(
   parameter int unsigned IMG_W = 200,
   parameter int unsigned IMG_H = 200
);
   localparam int unsigned XW = $clog2(IMG_W);
   localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   logic          new_trans;
   logic          blur_complete;
   logic [7:0]    blurred_pixel;
   logic          wack;
   logic          wen_out;
   logic [XW-1:0] x_addr_out;
   logic [YW-1:0] y_addr_out;
   logic [7:0]    wdat_out;
   logic          frame_done;
   logic          busy;
   logic          err;

   modport slave (
      input  new_trans, blur_complete, blurred_pixel, wack,
      output wen_out, x_addr_out, y_addr_out, wdat_out, frame_done, busy, err
   );

   modport master (
      output new_trans, blur_complete, blurred_pixel, wack,
      input  wen_out, x_addr_out, y_addr_out, wdat_out, frame_done, busy, err
   );
endinterface

// File: rtl/blur_writeback.sv
// Blurred-pixel writeback: tags each pixel with its scan-order coordinate, queues it,
// and writes it to the blurred-image memory through a wen/wack handshake.
module blur_writeback #(
   parameter int unsigned IMG_W      = 200,
   parameter int unsigned IMG_H      = 200,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned SERPENTINE = 1
) (
   input logic             clk,
   input logic             n_rst,
   blur_writeback_if.slave bus
);
   localparam int unsigned XW    = $clog2(IMG_W);
   localparam int unsigned YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int unsigned PW    = $clog2(FIFO_DEPTH);
   localparam int unsigned TOTAL = IMG_W * IMG_H;
   localparam int unsigned CW    = $clog2(TOTAL + 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   typedef struct packed {
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      logic [7:0]    pix;
   } entry_t;

   state_t        state;
   entry_t        mem [FIFO_DEPTH];
   entry_t        head;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic [PW:0]   count_nxt;
   logic [XW-1:0] x;
   logic [XW-1:0] x_nxt;
   logic [YW-1:0] y;
   logic [YW-1:0] y_nxt;
   logic [CW-1:0] pix_cnt;
   logic          err;
   logic          frame_done;
   logic          empty;
   logic          full;
   logic          pop;
   logic          in_run;
   logic          push;
   logic          drop;
   logic          stray;
   logic          last_px;

   // Handshake qualifiers; a full FIFO still accepts a push when it pops in the same cycle
   always_comb begin
      empty   = (count == '0);
      full    = (count == (PW+1)'(FIFO_DEPTH));
      pop     = !empty && bus.wack;
      in_run  = (state == RUN) && bus.blur_complete;
      push    = in_run && (!full || pop);
      drop    = in_run && full && !pop;
      stray   = bus.blur_complete && (state != RUN);
      last_px = in_run && (pix_cnt == CW'(TOTAL - 1));
      count_nxt = count;
      if (push && !pop)
         count_nxt = count + (PW+1)'(1);
      else if (!push && pop)
         count_nxt = count - (PW+1)'(1);
   end

   // Scan-order coordinate advance; wraps to the origin after the final pixel of the frame
   always_comb begin
      x_nxt = x;
      y_nxt = y;
      if (last_px) begin
         x_nxt = '0;
         y_nxt = '0;
      end else if ((SERPENTINE != 0) && y[0]) begin
         if (x == '0)
            y_nxt = y + YW'(1);
         else
            x_nxt = x - XW'(1);
      end else begin
         if (x == XW'(IMG_W - 1)) begin
            y_nxt = y + YW'(1);
            if (SERPENTINE == 0)
               x_nxt = '0;
         end else begin
            x_nxt = x + XW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         x          <= '0;
         y          <= '0;
         pix_cnt    <= '0;
         err        <= 1'b0;
         frame_done <= 1'b0;
      end else if (bus.new_trans) begin
         state      <= RUN;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         x          <= '0;
         y          <= '0;
         pix_cnt    <= '0;
         err        <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         count      <= count_nxt;
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         if (drop || stray)
            err <= 1'b1;
         // Dropped pixels still consume a coordinate so later pixels land correctly
         if (in_run) begin
            x       <= x_nxt;
            y       <= y_nxt;
            pix_cnt <= last_px ? '0 : pix_cnt + CW'(1);
         end
         case (state)
            RUN: begin
               if (last_px) begin
                  if (count_nxt == '0) begin
                     state      <= DONE;
                     frame_done <= 1'b1;
                  end else begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (count_nxt == '0) begin
                  state      <= DONE;
                  frame_done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Queue storage needs no reset: the head is only exposed while the FIFO is non-empty
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {x, y, bus.blurred_pixel};
   end

   assign head           = mem[rd_ptr];
   assign bus.wen_out    = !empty;
   assign bus.x_addr_out = empty ? '0 : head.x;
   assign bus.y_addr_out = empty ? '0 : head.y;
   assign bus.wdat_out   = empty ? '0 : head.pix;
   assign bus.frame_done = frame_done;
   assign bus.busy       = (state == RUN) || (state == DRAIN);
   assign bus.err        = err;
endmodule

// File: tb/tb_blur_writeback.sv
// Directed bench for blur_writeback on a 4x3 image: serpentine DUT plus a raster-order DUT.
module tb_blur_writeback;
   logic clk;
   logic n_rst;
   int   total;
   int   bad;
   int   fd_cnt;
   logic [11:0] log0[$];
   logic [11:0] log1[$];
   int   serp_x [12] = '{0, 1, 2, 3, 3, 2, 1, 0, 0, 1, 2, 3};
   int   serp_y [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};

   blur_writeback_if #(.IMG_W(4), .IMG_H(3)) b0 ();
   blur_writeback_if #(.IMG_W(4), .IMG_H(3)) b1 ();

   blur_writeback #(.IMG_W(4), .IMG_H(3), .FIFO_DEPTH(4), .SERPENTINE(1)) dut0 (
      .clk(clk), .n_rst(n_rst), .bus(b0));
   blur_writeback #(.IMG_W(4), .IMG_H(3), .FIFO_DEPTH(4), .SERPENTINE(0)) dut1 (
      .clk(clk), .n_rst(n_rst), .bus(b1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every accepted write, sampled mid-cycle while inputs are stable
   always @(negedge clk) begin
      if (b0.wen_out && b0.wack) log0.push_back({b0.x_addr_out, b0.y_addr_out, b0.wdat_out});
      if (b1.wen_out && b1.wack) log1.push_back({b1.x_addr_out, b1.y_addr_out, b1.wdat_out});
      if (b0.frame_done) fd_cnt++;
   end

   function automatic logic [11:0] mk(input int xx, input int yy, input int dd);
      return {2'(xx), 2'(yy), 8'(dd)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic new_frame();
      b0.new_trans = 1'b1;
      step();
      b0.new_trans = 1'b0;
   endtask

   task automatic push_seq(input int n, input int base, input logic wk);
      for (int i = 0; i < n; i++) begin
         b0.blur_complete = 1'b1;
         b0.blurred_pixel = 8'(base + i);
         b0.wack          = wk;
         step();
      end
      b0.blur_complete = 1'b0;
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      step();
      step();
      total++; if (b0.wen_out !== 1'b0) begin bad++; $display("FAIL reset_wen got=%0b exp=0", b0.wen_out); end
      total++; if ({b0.x_addr_out, b0.y_addr_out, b0.wdat_out} !== 12'h0) begin bad++; $display("FAIL reset_addr_data got=%0h exp=0", {b0.x_addr_out, b0.y_addr_out, b0.wdat_out}); end
      total++; if ({b0.frame_done, b0.busy, b0.err} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%0b exp=000", {b0.frame_done, b0.busy, b0.err}); end
      n_rst = 1'b1;
      step();
   endtask

   task automatic test_frame();
      log0.delete();
      fd_cnt = 0;
      new_frame();
      for (int i = 0; i < 12; i++) begin
         b0.blur_complete = 1'b1;
         b0.blurred_pixel = 8'(8'h10 + i);
         b0.wack          = 1'b1;
         step();
         if (i == 0) begin
            total++; if ({b0.wen_out, b0.x_addr_out, b0.y_addr_out, b0.wdat_out} !== {1'b1, 12'h010}) begin bad++; $display("FAIL frame_latency got=%0h exp=1010", {b0.wen_out, b0.x_addr_out, b0.y_addr_out, b0.wdat_out}); end
         end
      end
      b0.blur_complete = 1'b0;
      step();
      total++; if ({b0.frame_done, b0.wen_out} !== 2'b10) begin bad++; $display("FAIL frame_done_assert got=%0b exp=10", {b0.frame_done, b0.wen_out}); end
      step();
      total++; if (b0.frame_done !== 1'b0) begin bad++; $display("FAIL frame_done_pulse got=%0b exp=0", b0.frame_done); end
      step();
      total++; if (log0.size() !== 12) begin bad++; $display("FAIL frame_count got=%0d exp=12", log0.size()); end
      for (int i = 0; i < 12; i++) begin
         total++; if (log0[i] !== mk(serp_x[i], serp_y[i], 8'h10 + i)) begin bad++; $display("FAIL frame_write%0d got=%0h exp=%0h", i, log0[i], mk(serp_x[i], serp_y[i], 8'h10 + i)); end
      end
      total++; if ({fd_cnt, b0.err, b0.busy} !== {32'd1, 2'b00}) begin bad++; $display("FAIL frame_fd_err_busy got fd=%0d err=%0b busy=%0b exp 1 0 0", fd_cnt, b0.err, b0.busy); end
   endtask

   task automatic test_full();
      new_frame();
      push_seq(4, 8'h20, 1'b0);
      total++; if (b0.err !== 1'b0) begin bad++; $display("FAIL full_no_err got=%0b exp=0", b0.err); end
      push_seq(1, 8'h24, 1'b0);
      total++; if ({b0.err, b0.wen_out, b0.x_addr_out, b0.y_addr_out, b0.wdat_out} !== {2'b11, 12'h020}) begin bad++; $display("FAIL full_drop got=%0h exp=3020", {b0.err, b0.wen_out, b0.x_addr_out, b0.y_addr_out, b0.wdat_out}); end
      step();
      step();
      total++; if ({b0.wen_out, b0.x_addr_out, b0.y_addr_out, b0.wdat_out} !== {1'b1, 12'h020}) begin bad++; $display("FAIL full_hold got=%0h exp=1020", {b0.wen_out, b0.x_addr_out, b0.y_addr_out, b0.wdat_out}); end
      log0.delete();
      b0.wack = 1'b1;
      repeat (4) step();
      total++; if (b0.wen_out !== 1'b0) begin bad++; $display("FAIL full_drained got=%0b exp=0", b0.wen_out); end
      push_seq(2, 8'h25, 1'b1);
      step();
      step();
      total++; if (log0.size() !== 6) begin bad++; $display("FAIL full_count got=%0d exp=6", log0.size()); end
      total++; if (log0[3] !== mk(3, 0, 8'h23)) begin bad++; $display("FAIL full_w3 got=%0h exp=%0h", log0[3], mk(3, 0, 8'h23)); end
      total++; if (log0[4] !== mk(2, 1, 8'h25)) begin bad++; $display("FAIL full_w4 got=%0h exp=%0h", log0[4], mk(2, 1, 8'h25)); end
      total++; if (log0[5] !== mk(1, 1, 8'h26)) begin bad++; $display("FAIL full_w5 got=%0h exp=%0h", log0[5], mk(1, 1, 8'h26)); end
      total++; if (b0.err !== 1'b1) begin bad++; $display("FAIL full_err_sticky got=%0b exp=1", b0.err); end
   endtask

   task automatic test_flush();
      push_seq(3, 8'h40, 1'b0);
      total++; if ({b0.wen_out, b0.err} !== 2'b11) begin bad++; $display("FAIL flush_pre got=%0b exp=11", {b0.wen_out, b0.err}); end
      b0.new_trans     = 1'b1;
      b0.blur_complete = 1'b1;
      b0.blurred_pixel = 8'h99;
      step();
      b0.new_trans     = 1'b0;
      b0.blur_complete = 1'b0;
      total++; if ({b0.wen_out, b0.err, b0.busy} !== 3'b001) begin bad++; $display("FAIL flush_clear got=%0b exp=001", {b0.wen_out, b0.err, b0.busy}); end
      log0.delete();
      push_seq(1, 8'h50, 1'b1);
      step();
      step();
      total++; if (log0.size() !== 1 || log0[0] !== mk(0, 0, 8'h50)) begin bad++; $display("FAIL flush_next got n=%0d w=%0h exp n=1 w=%0h", log0.size(), log0[0], mk(0, 0, 8'h50)); end
      total++; if (b0.err !== 1'b0) begin bad++; $display("FAIL flush_err got=%0b exp=0", b0.err); end
   endtask

   task automatic test_back_to_back();
      new_frame();
      push_seq(4, 8'h30, 1'b0);
      log0.delete();
      push_seq(1, 8'h34, 1'b1);
      total++; if ({b0.err, b0.wen_out, b0.x_addr_out, b0.y_addr_out, b0.wdat_out} !== {2'b01, 12'h431}) begin bad++; $display("FAIL b2b_both got=%0h exp=1431", {b0.err, b0.wen_out, b0.x_addr_out, b0.y_addr_out, b0.wdat_out}); end
      b0.wack = 1'b1;
      repeat (3) step();
      total++; if ({b0.wen_out, b0.x_addr_out, b0.y_addr_out, b0.wdat_out} !== {1'b1, 12'hD34}) begin bad++; $display("FAIL b2b_last_entry got=%0h exp=1d34", {b0.wen_out, b0.x_addr_out, b0.y_addr_out, b0.wdat_out}); end
      step();
      total++; if (b0.wen_out !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%0b exp=0", b0.wen_out); end
      total++; if (log0.size() !== 5 || log0[0] !== mk(0, 0, 8'h30) || log0[4] !== mk(3, 1, 8'h34)) begin bad++; $display("FAIL b2b_log got n=%0d w0=%0h w4=%0h", log0.size(), log0[0], log0[4]); end
   endtask

   task automatic test_done();
      new_frame();
      push_seq(12, 8'h60, 1'b1);
      step();
      step();
      total++; if ({b0.err, b0.busy} !== 2'b00) begin bad++; $display("FAIL done_clean got=%0b exp=00", {b0.err, b0.busy}); end
      push_seq(1, 8'hEE, 1'b1);
      total++; if ({b0.wen_out, b0.err, b0.busy} !== 3'b010) begin bad++; $display("FAIL done_stray got=%0b exp=010", {b0.wen_out, b0.err, b0.busy}); end
      new_frame();
      total++; if (b0.err !== 1'b0) begin bad++; $display("FAIL droplast_err_clear got=%0b exp=0", b0.err); end
      push_seq(12, 8'h80, 1'b0);
      total++; if ({b0.busy, b0.frame_done, b0.err} !== 3'b101) begin bad++; $display("FAIL droplast_drain got=%0b exp=101", {b0.busy, b0.frame_done, b0.err}); end
      b0.wack = 1'b1;
      repeat (3) step();
      total++; if ({b0.wen_out, b0.frame_done} !== 2'b10) begin bad++; $display("FAIL droplast_early got=%0b exp=10", {b0.wen_out, b0.frame_done}); end
      step();
      total++; if ({b0.wen_out, b0.frame_done} !== 2'b01) begin bad++; $display("FAIL droplast_done got=%0b exp=01", {b0.wen_out, b0.frame_done}); end
      step();
      total++; if ({b0.frame_done, b0.busy} !== 2'b00) begin bad++; $display("FAIL droplast_pulse got=%0b exp=00", {b0.frame_done, b0.busy}); end
      new_frame();
      push_seq(5, 8'hA0, 1'b0);
      n_rst = 1'b0;
      step();
      n_rst = 1'b1;
      total++; if ({b0.wen_out, b0.x_addr_out, b0.y_addr_out, b0.wdat_out, b0.frame_done, b0.busy, b0.err} !== 16'h0) begin bad++; $display("FAIL midreset got=%0h exp=0", {b0.wen_out, b0.x_addr_out, b0.y_addr_out, b0.wdat_out, b0.frame_done, b0.busy, b0.err}); end
   endtask

   task automatic test_raster();
      log1.delete();
      b1.new_trans = 1'b1;
      step();
      b1.new_trans = 1'b0;
      for (int i = 0; i < 8; i++) begin
         b1.blur_complete = 1'b1;
         b1.blurred_pixel = 8'(8'h70 + i);
         b1.wack          = 1'b1;
         step();
      end
      b1.blur_complete = 1'b0;
      step();
      step();
      total++; if (log1.size() !== 8) begin bad++; $display("FAIL raster_count got=%0d exp=8", log1.size()); end
      total++; if (log1[4] !== mk(0, 1, 8'h74)) begin bad++; $display("FAIL raster_w4 got=%0h exp=%0h", log1[4], mk(0, 1, 8'h74)); end
      total++; if (log1[7] !== mk(3, 1, 8'h77)) begin bad++; $display("FAIL raster_w7 got=%0h exp=%0h", log1[7], mk(3, 1, 8'h77)); end
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      fd_cnt = 0;
      n_rst  = 1'b0;
      b0.new_trans = 1'b0; b0.blur_complete = 1'b0; b0.blurred_pixel = 8'h0; b0.wack = 1'b0;
      b1.new_trans = 1'b0; b1.blur_complete = 1'b0; b1.blurred_pixel = 8'h0; b1.wack = 1'b0;
      test_reset();
      test_frame();
      test_full();
      test_flush();
      test_back_to_back();
      test_done();
      test_raster();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
